// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the register hazard scoreboard.
// HSB_SRC extracts operand k from a packed source-index vector.
`ifndef HSB_SRC
`define HSB_SRC(vec, k, aw) vec[(k)*(aw) +: (aw)]
`endif

package hazard_scoreboard_pkg;
  localparam int LW_DEFAULT  = 3;
  localparam int SCW_DEFAULT = 16;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown to forwarding availability plus a writeback-pending bit.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LW = LW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_i,
  input  logic [LW-1:0] lat_i,
  input  logic          wb_i,
  output logic [LW-1:0] cnt_o,
  output logic          pend_o
);

  logic [LW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  // A new producer outranks a retiring older one for the same register.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (issue_i) begin
      cnt_d  = lat_i;
      pend_d = 1'b1;
    end else if (wb_i) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write scoreboard raising stall for multi-cycle producers
// and ID-resolved branches, with a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int LW   = LW_DEFAULT,
  parameter int SCW  = SCW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC-1:0]    src_valid_i,
  input  logic [NSRC*AW-1:0] src_i,
  input  logic               branch_i,
  input  logic               issue_valid_i,
  input  logic               issue_regwrite_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic [LW-1:0]      issue_lat_i,
  input  logic               flush_i,
  input  logic               wb_valid_i,
  input  logic [AW-1:0]      wb_rd_i,
  output logic               stall_o,
  output logic [SCW-1:0]     stall_cnt_o
);

  logic [LW-1:0]   cnt_w [1:NREG-1];
  logic [NREG-1:1] pend_w;
  logic [NREG-1:1] busy_w;
  logic [NSRC-1:0] src_haz;
  logic            do_issue;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;

  assign do_issue = issue_valid_i & ~stall_o & ~flush_i & issue_regwrite_i
                  & (issue_rd_i != '0);

  // Entry 0 and indices >= NREG have no entry, so they never match.
  for (genvar r = 1; r < NREG; r++) begin : g_entry
    hazard_sb_entry #(.LW(LW)) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .issue_i(do_issue && (issue_rd_i == AW'(r))),
      .lat_i  (issue_lat_i),
      .wb_i   (wb_valid_i && (wb_rd_i == AW'(r))),
      .cnt_o  (cnt_w[r]),
      .pend_o (pend_w[r])
    );
    assign busy_w[r] = (cnt_w[r] != '0);
  end

  // Branches compare in ID without forwarding, so they wait for writeback.
  always_comb begin
    src_haz = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (src_valid_i[k] && (`HSB_SRC(src_i, k, AW) == AW'(r))) begin
          src_haz[k] = branch_i ? pend_w[r] : busy_w[r];
        end
      end
    end
  end

  assign stall_o = (|src_haz) & ~flush_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
